// File: rtl/srt_digit_gen.sv
// Radix-2 SRT quotient digit generator, 16 digits MSB first.
// Digit 1 appears the cycle after the accepting edge; no stall, output consumer must keep up.
module srt_digit_gen (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [15:0] dividend,
   input  logic [15:0] divisor,
   output logic        ready,
   output logic        valid,
   output logic [1:0]  digit,
   output logic        last,
   output logic        done,
   output logic [18:0] rem,
   output logic        rem_neg,
   output logic        err
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [1:0] DIG_ZERO = 2'b00;
   localparam logic [1:0] DIG_POS  = 2'b01;
   localparam logic [1:0] DIG_NEG  = 2'b10;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [18:0] w_q, w_d;
   logic [15:0] d_q, d_d;
   logic        valid_q, valid_d;
   logic [1:0]  digit_q, digit_d;
   logic        last_q, last_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic [18:0] rem_q, rem_d;

   logic        accept;
   logic        reject;
   logic [18:0] step_w;
   logic [15:0] step_d;
   logic [18:0] p;
   logic [18:0] p_sub;
   logic [18:0] p_add;
   logic [18:0] step_w_nxt;
   logic [1:0]  step_dig;

   assign accept = (state_q == S_IDLE) && start && divisor[15] && (dividend < divisor);
   assign reject = (state_q == S_IDLE) && start && !accept;

   // The first step is taken from the live operands so digit 1 is ready one edge after accept.
   assign step_w = (state_q == S_IDLE) ? {3'b000, dividend} : w_q;
   assign step_d = (state_q == S_IDLE) ? divisor : d_q;

   assign p     = {step_w[17:0], 1'b0};
   assign p_sub = p - {3'b000, step_d};
   assign p_add = p + {3'b000, step_d};

   // Selection constants are +1/2 and -1/2 in Q3.16.
   always_comb begin
      step_w_nxt = p;
      step_dig   = DIG_ZERO;
      if ($signed(p) >= $signed(19'h08000)) begin
         step_w_nxt = p_sub;
         step_dig   = DIG_POS;
      end else if ($signed(p) < $signed(19'h78000)) begin
         step_w_nxt = p_add;
         step_dig   = DIG_NEG;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w_d     = w_q;
      d_d     = d_q;
      valid_d = 1'b0;
      digit_d = DIG_ZERO;
      last_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b0;
      rem_d   = rem_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = S_RUN;
               cnt_d   = 4'd0;
               d_d     = divisor;
               w_d     = step_w_nxt;
               valid_d = 1'b1;
               digit_d = step_dig;
            end else if (reject) begin
               err_d = 1'b1;
            end
         end
         S_RUN: begin
            if (cnt_q == 4'd15) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               rem_d   = w_q;
            end else begin
               cnt_d   = cnt_q + 4'd1;
               w_d     = step_w_nxt;
               valid_d = 1'b1;
               digit_d = step_dig;
               last_d  = (cnt_q == 4'd14);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         w_q     <= 19'd0;
         d_q     <= 16'd0;
         valid_q <= 1'b0;
         digit_q <= DIG_ZERO;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rem_q   <= 19'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         w_q     <= w_d;
         d_q     <= d_d;
         valid_q <= valid_d;
         digit_q <= digit_d;
         last_q  <= last_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rem_q   <= rem_d;
      end
   end

   assign ready   = (state_q == S_IDLE);
   assign valid   = valid_q;
   assign digit   = digit_q;
   assign last    = last_q;
   assign done    = done_q;
   assign err     = err_q;
   assign rem     = rem_q;
   assign rem_neg = rem_q[18];

endmodule
